mul3_pipe_multi: RTL and testbench
==================================

// Module: mul3_pipe_multi
// PURPOSE
//  Parametrised, multi-lane successor of the bicubic weight multiplier: computes a*b*c per lane.
//  Uses a valid/ready pipeline with full-stall backpressure, plus an optional round/shift stage
//  that narrows the result. Sits in the bicubic weight path (quanzhong) between the coefficient
//  generator and the 4x4 weighting accumulator. All operands are unsigned.
// PARAMETERS
//  NUM_CH     4    number of independent lanes; all lanes share one valid/ready pair
//  A_W        18   width of operand a per lane
//  B_W        10   width of operand b per lane
//  C_W        10   width of operand c per lane
//  EXTRA_STG  1    delay stages between the b*c stage and the *a stage (0..4)
//  SHIFT      0    right shift applied to the full product, with round-half-up; 0 = no rounding
//  OUT_W      38   output width per lane (<= A_W+B_W+C_W-SHIFT)
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 asynchronous reset, active-low
//  in_valid   in   1                 input beat valid
//  in_ready   out  1                 input beat accepted when in_valid & in_ready
//  a          in   NUM_CH*A_W        packed lane operands; lane k = [k*A_W +: A_W]
//  b          in   NUM_CH*B_W        packed, same lane packing as a
//  c          in   NUM_CH*C_W        packed, same lane packing as a
//  out_valid  out  1                 result beat valid
//  out_ready  in   1                 downstream accepts the beat
//  result     out  NUM_CH*OUT_W      packed lane results
//  ovf        out  NUM_CH            per-lane overflow flag, aligned with result (MUL3_SAT_EN only; else 0)
// BEHAVIOUR
//  - Stage map: S1 p=b*c (B_W+C_W) with a registered | S2..S(1+EXTRA_STG) delay of p and a |
//    S(2+EXTRA_STG) full=p*a (A_W+B_W+C_W) | final stage round/shift/narrow -> result.
//  - Latency LAT = 3+EXTRA_STG cycles from the accepted input to out_valid, with no stall.
//  - Every stage carries a valid bit. Every data and valid register is reset asynchronously to 0.
//  - Reset outputs: out_valid=0, result=0, ovf=0, in_ready=1.
//  - Global enable: adv = ~out_valid | out_ready. The whole pipe shifts only when adv=1.
//    Bubbles are not collapsed. in_ready = adv.
//  - Stall (out_valid=1, out_ready=0): result, ovf and every stage hold. No beat is lost or
//    duplicated. in_valid while in_ready=0 is ignored.
//  - Input accept and output drain in the same cycle are allowed: full throughput, 1 beat/clk.
//  - Round: r = (full + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT.
//    The rounding adder is 1 bit wider than full, so the carry is never lost.
//  - Narrow without MUL3_SAT_EN: result = r[OUT_W-1:0] (wraps); ovf tied to 0.
//  - rst_n asserted mid-operation: all in-flight beats are discarded. First output after
//    release comes only from an input accepted after release.
//  - Defaults (NUM_CH=1, EXTRA_STG=1, SHIFT=0, OUT_W=38, out_ready=1) reproduce legacy
//    mul_3 values and 4-cycle latency.
// CONFIGURATION
//  MUL3_SAT_EN defined: if r > 2^OUT_W-1, result = 2^OUT_W-1 and ovf[k]=1 for that beat only;
//    otherwise ovf[k]=0. Adds one compare per lane at the final stage; latency unchanged.
//  MUL3_SAT_EN undefined: wrap-around truncation; ovf output is constant 0.
// TESTING
//  1 Default params, NUM_CH=1, out_ready=1: a=200000, b=1000, c=1000 for one beat
//    -> out_valid exactly 4 clks later, result=200000000000.
//  2 Streaming, NUM_CH=4: 64 back-to-back random beats -> 64 results in order,
//    1 beat/clk, each matches the reference model.
//  3 Backpressure: hold out_ready=0 for 5 clks mid-stream -> in_ready=0, result stable,
//    no loss or duplication after release.
//  4 SHIFT=10, OUT_W=20: a=1023, b=3, c=1 (full=3069) -> result=3 (3069/1024 = 2.997, rounded up).
//  5 MUL3_SAT_EN, SHIFT=0, OUT_W=16: a=300, b=300, c=1 -> result=65535, ovf=1.
//    The next beat a=b=c=2 -> result=8, ovf=0.
//  6 Reset with 3 beats in flight -> out_valid=0 and result=0 immediately;
//    no stale beat appears after release.

Source files
------------

// File: rtl/mul3_pipe_multi.sv
// mul3_pipe_multi: multi-lane unsigned a*b*c multiplier for the bicubic weight path.
// Stage map: b*c and a registered, EXTRA_STG delay stages, *a stage, round/shift/narrow stage.
// The whole pipe advances on one shared enable, so backpressure stalls every stage together.
// Optional feature macro: MUL3_SAT_EN. When it is defined, each lane saturates to 2^OUT_W-1
// and raises ovf. When it is undefined, the result wraps and ovf is tied to 0.
module mul3_pipe_multi #(
  parameter int NUM_CH    = 4,
  parameter int A_W       = 18,
  parameter int B_W       = 10,
  parameter int C_W       = 10,
  parameter int EXTRA_STG = 1,
  parameter int SHIFT     = 0,
  parameter int OUT_W     = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*A_W-1:0]   a,
  input  logic [NUM_CH*B_W-1:0]   b,
  input  logic [NUM_CH*C_W-1:0]   c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] result,
  output logic [NUM_CH-1:0]       ovf
);

  localparam int P_W    = B_W + C_W;
  localparam int FULL_W = A_W + P_W;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Half an output LSB, added before the shift for round-half-up; zero when SHIFT is 0.
  localparam logic [FULL_W:0] RND = (SHIFT > 0) ? ({{FULL_W{1'b0}}, 1'b1} << RND_SH) : '0;

  logic adv;
  logic v_pipe [0:EXTRA_STG];
  logic full_valid;
  logic out_valid_reg;

  // The pipe only moves when the output slot is empty or is being drained this cycle.
  assign adv       = ~out_valid_reg | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;

  // Valid chain: one bit per stage; bubbles travel down the pipe and are not collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= EXTRA_STG; s++) begin
        v_pipe[s] <= 1'b0;
      end
      full_valid    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (adv) begin
      v_pipe[0] <= in_valid;
      for (int s = 1; s <= EXTRA_STG; s++) begin
        v_pipe[s] <= v_pipe[s-1];
      end
      full_valid    <= v_pipe[EXTRA_STG];
      out_valid_reg <= full_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [A_W-1:0]    a_in;
      logic [B_W-1:0]    b_in;
      logic [C_W-1:0]    c_in;
      logic [P_W-1:0]    p_next;
      logic [P_W-1:0]    p_pipe [0:EXTRA_STG];
      logic [A_W-1:0]    a_pipe [0:EXTRA_STG];
      logic [FULL_W-1:0] full_next;
      logic [FULL_W-1:0] full_reg;
      logic [FULL_W:0]   rnd_sum;
      logic [OUT_W-1:0]  res_next;
      logic [OUT_W-1:0]  res_reg;

      assign a_in      = a[gi*A_W +: A_W];
      assign b_in      = b[gi*B_W +: B_W];
      assign c_in      = c[gi*C_W +: C_W];
      assign p_next    = P_W'(b_in) * P_W'(c_in);
      assign full_next = FULL_W'(p_pipe[EXTRA_STG]) * FULL_W'(a_pipe[EXTRA_STG]);
      // One bit wider than the product so the rounding carry survives.
      assign rnd_sum   = {1'b0, full_reg} + RND;

      // Partial product b*c and operand a, then the delay stages that carry both.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s <= EXTRA_STG; s++) begin
            p_pipe[s] <= '0;
            a_pipe[s] <= '0;
          end
        end else if (adv) begin
          p_pipe[0] <= p_next;
          a_pipe[0] <= a_in;
          for (int s = 1; s <= EXTRA_STG; s++) begin
            p_pipe[s] <= p_pipe[s-1];
            a_pipe[s] <= a_pipe[s-1];
          end
        end
      end

      // Full-width product stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          full_reg <= '0;
        end else if (adv) begin
          full_reg <= full_next;
        end
      end

`ifdef MUL3_SAT_EN
      logic [FULL_W:0] r_full;
      logic            over;
      logic            ovf_reg;

      assign r_full   = rnd_sum >> SHIFT;
      assign over     = |r_full[FULL_W:OUT_W];
      assign res_next = over ? {OUT_W{1'b1}} : r_full[OUT_W-1:0];

      // Overflow flag travels with the beat it belongs to.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= over;
        end
      end

      assign ovf[gi] = ovf_reg;
`else
      assign res_next = OUT_W'(rnd_sum >> SHIFT);
`endif

      // Output register: rounded, shifted and narrowed lane result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg <= '0;
        end else if (adv) begin
          res_reg <= res_next;
        end
      end

      assign result[gi*OUT_W +: OUT_W] = res_reg;
    end
  endgenerate

`ifndef MUL3_SAT_EN
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_mul3_pipe_multi.sv
// Bench for mul3_pipe_multi: four instances run in lockstep on one shared handshake.
// dut0 is 4 lanes with default parameters. dut1 is a single lane with legacy values.
// dut2 uses SHIFT=10 and OUT_W=20. dut3 uses OUT_W=16, which exercises the overflow path.
// Expected results come from plain arithmetic on a queue of accepted beats.
module tb_mul3_pipe_multi;

`ifdef MUL3_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [71:0]  a_in;
  logic [39:0]  b_in;
  logic [39:0]  c_in;

  logic         in_ready0, in_ready1, in_ready2, in_ready3;
  logic         out_valid0, out_valid1, out_valid2, out_valid3;
  logic [151:0] result0;
  logic [37:0]  result1;
  logic [19:0]  result2;
  logic [15:0]  result3;
  logic [3:0]   ovf0;
  logic         ovf1, ovf2, ovf3;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;

  typedef struct {
    logic [71:0] a;
    logic [39:0] b;
    logic [39:0] c;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  mul3_pipe_multi dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a_in), .b(b_in), .c(c_in),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .ovf(ovf0)
  );

  mul3_pipe_multi #(.NUM_CH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a_in[17:0]), .b(b_in[9:0]), .c(c_in[9:0]),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .ovf(ovf1)
  );

  mul3_pipe_multi #(.NUM_CH(1), .SHIFT(10), .OUT_W(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a_in[17:0]), .b(b_in[9:0]), .c(c_in[9:0]),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .ovf(ovf2)
  );

  mul3_pipe_multi #(.NUM_CH(1), .SHIFT(0), .OUT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .a(a_in[17:0]), .b(b_in[9:0]), .c(c_in[9:0]),
    .out_valid(out_valid3), .out_ready(out_ready), .result(result3), .ovf(ovf3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: product, round-half-up shift, then wrap or saturate to ow bits.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [63:0] z, input int sh, input int ow,
                                        output logic o);
    logic [63:0] full, r, mx;
    full = x * y * z;
    r    = (full + ((sh > 0) ? (64'd1 << (sh - 1)) : 64'd0)) >> sh;
    mx   = (64'd1 << ow) - 64'd1;
    if (SAT && (r > mx)) begin
      o = 1'b1;
      return mx;
    end
    o = 1'b0;
    return r & mx;
  endfunction

  // Scoreboard: record beats when accepted, compare every DUT when a beat is drained.
  always @(negedge clk) begin : monitor
    beat_t       bt;
    logic [63:0] e;
    logic        o;
    if (rst_n) begin
      if (out_valid0 && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          bt = q.pop_front();
          popped++;
          for (int k = 0; k < 4; k++) begin
            e = model(64'(bt.a[k*18 +: 18]), 64'(bt.b[k*10 +: 10]), 64'(bt.c[k*10 +: 10]), 0, 38, o);
            check($sformatf("dut0_lane%0d", k), 64'(result0[k*38 +: 38]), e);
            check($sformatf("dut0_ovf%0d", k), 64'(ovf0[k]), 64'(o));
          end
          e = model(64'(bt.a[17:0]), 64'(bt.b[9:0]), 64'(bt.c[9:0]), 0, 38, o);
          check("dut1_result", 64'(result1), e);
          check("dut1_valid", 64'(out_valid1), 64'd1);
          e = model(64'(bt.a[17:0]), 64'(bt.b[9:0]), 64'(bt.c[9:0]), 10, 20, o);
          check("dut2_result", 64'(result2), e);
          check("dut2_valid", 64'(out_valid2), 64'd1);
          e = model(64'(bt.a[17:0]), 64'(bt.b[9:0]), 64'(bt.c[9:0]), 0, 16, o);
          check("dut3_result", 64'(result3), e);
          check("dut3_ovf", 64'(ovf3), 64'(o));
          check("dut3_valid", 64'(out_valid3), 64'd1);
          $display("beat %0d: a0=%0d b0=%0d c0=%0d r1=%0d r2=%0d r3=%0d ovf3=%0d",
                   popped, bt.a[17:0], bt.b[9:0], bt.c[9:0], result1, result2, result3, ovf3);
        end
      end
      if (in_valid && in_ready0) begin
        bt.a = a_in;
        bt.b = b_in;
        bt.c = c_in;
        q.push_back(bt);
        pushed++;
      end
    end
  end

  task automatic drive(input logic iv, input logic orr);
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = orr;
    for (int k = 0; k < 4; k++) begin
      a_in[k*18 +: 18] = 18'($urandom);
      b_in[k*10 +: 10] = 10'($urandom);
      c_in[k*10 +: 10] = 10'($urandom);
    end
  endtask

  task automatic set_lane0(input logic [17:0] x, input logic [9:0] y, input logic [9:0] z);
    a_in[17:0] = x;
    b_in[9:0]  = y;
    c_in[9:0]  = z;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
  endtask

  // Wait (bounded) for the lockstep output; returns 1 when out_valid0 is seen.
  task automatic wait_out(input string tag, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin : stim
    int          lat;
    logic        seen;
    logic [63:0] held;
    int          base;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    c_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_result", 64'(|result0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);
    check("rst_in_ready", 64'(in_ready0), 64'd1);
    rst_n = 1'b1;
    idle(2);

    // Legacy single beat: latency and value.
    drive(1'b1, 1'b1);
    set_lane0(18'd200000, 10'd1000, 10'd1000);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      lat++;
      #1 in_valid = 1'b0;
      @(negedge clk);
      if (out_valid1) begin
        seen = 1'b1;
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_result", 64'(result1), 64'd200000000000);
      end
    end
    if (!seen) check("t1_timeout", 64'd0, 64'd1);
    idle(6);

    // Rounding: 3069 / 1024 rounds up to 3.
    drive(1'b1, 1'b1);
    set_lane0(18'd1023, 10'd3, 10'd1);
    idle(1);
    wait_out("t4", seen);
    if (seen) check("t4_result", 64'(result2), 64'd3);
    idle(6);

    // Narrow to 16 bits: 90000 saturates or wraps, then a small beat follows.
    drive(1'b1, 1'b1);
    set_lane0(18'd300, 10'd300, 10'd1);
    drive(1'b1, 1'b1);
    set_lane0(18'd2, 10'd2, 10'd2);
    idle(1);
    wait_out("t5", seen);
    if (seen) begin
      check("t5_first_result", 64'(result3), SAT ? 64'd65535 : 64'd24464);
      check("t5_first_ovf", 64'(ovf3), SAT ? 64'd1 : 64'd0);
      @(negedge clk);
      check("t5_second_valid", 64'(out_valid3), 64'd1);
      check("t5_second_result", 64'(result3), 64'd8);
      check("t5_second_ovf", 64'(ovf3), 64'd0);
    end
    idle(6);

    // Streaming: 64 back-to-back beats must drain at one beat per clock.
    base = popped;
    for (int i = 0; i < 64; i++) drive(1'b1, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("stream_throughput", 64'(popped - base), 64'd64);
    idle(6);

    // Backpressure: out_ready low for 5 clocks mid-stream.
    held = '0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, !(i >= 15 && i < 20));
      if (i >= 15 && i < 20) begin
        @(negedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready0), 64'd0);
        check("stall_valid", 64'(out_valid0), 64'd1);
        if (i == 15) held = 64'(result0[37:0]);
        else check("stall_hold", 64'(result0[37:0]), held);
      end
    end
    idle(8);

    // Random valid and ready traffic.
    for (int i = 0; i < 300; i++) drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    idle(8);

    // Reset with beats in flight.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid0), 64'd0);
    check("midrst_result", 64'(|result0), 64'd0);
    check("midrst_result1", 64'(result1), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    check("postrst_no_stale", 64'(seen), 64'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    idle(10);

    check("queue_empty", 64'(q.size()), 64'd0);
    check("popped_nonzero", 64'(popped > 100), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
